// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the N-way round-robin / fixed-priority memory arbiter.
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RELEASE
  } arb_state_t;

  typedef logic [127:0] lc3b_line;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Requester-side and downstream-side signals of mem_arbiter_rr.
// master: the arbiter itself; slave: the caches/L2 environment around it.
interface mem_arbiter_rr_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = 16,
  parameter int unsigned LW    = 128,
  localparam int unsigned IW   = mem_arbiter_rr_pkg::idx_width(N_REQ)
);

  logic [N_REQ-1:0]    req_read;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*AW-1:0] req_address;
  logic [N_REQ*LW-1:0] req_wdata;
  logic [LW-1:0]       req_rdata;
  logic [N_REQ-1:0]    req_resp;
  logic                mem_read;
  logic                mem_write;
  logic [AW-1:0]       mem_address;
  logic [LW-1:0]       mem_wdata;
  logic [LW-1:0]       mem_rdata;
  logic                mem_resp;
  logic [IW-1:0]       grant_id;
  logic                busy;

  modport master (
    input  req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, grant_id, busy
  );

  modport slave (
    output req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, grant_id, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational requester picker: first active index scanning up from the
// pointer (round-robin) or lowest active index (fixed priority).
module rr_priority_picker import mem_arbiter_rr_pkg::*; #(
  parameter int unsigned N_REQ   = 2,
  parameter bit          RR_MODE = 1'b1,
  localparam int unsigned IW     = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] request,
  input  logic [IW-1:0]    pointer,
  output logic             valid,
  output logic [IW-1:0]    index
);

  always_comb begin
    int unsigned idx;
    valid = 1'b0;
    index = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = RR_MODE ? (32'(pointer) + k) % N_REQ : k;
      if (!valid && request[idx]) begin
        valid = 1'b1;
        index = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-way line arbiter in front of the L2: grants one requester at a time and
// drives registered downstream controls, with a dead cycle after each completion.
module mem_arbiter_rr import mem_arbiter_rr_pkg::*; #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned LW      = 128,
  parameter bit          RR_MODE = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mem_arbiter_rr_if.master bus
);

  localparam int unsigned IW = idx_width(N_REQ);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] wdata_q, wdata_d;

  logic [N_REQ-1:0] active;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  assign active = bus.req_read | bus.req_write;

  rr_priority_picker #(
    .N_REQ   (N_REQ),
    .RR_MODE (RR_MODE)
  ) u_picker (
    .request (active),
    .pointer (ptr_q),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_idx;
          addr_d      = bus.req_address[pick_idx*AW +: AW];
          wdata_d     = bus.req_wdata[pick_idx*LW +: LW];
          // A simultaneous read and write resolves to the write.
          mem_write_d = bus.req_write[pick_idx];
          mem_read_d  = bus.req_read[pick_idx] & ~bus.req_write[pick_idx];
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          ptr_d       = (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Completion is forwarded combinationally, only while a transaction is open.
  assign bus.req_resp    = (state_q == S_BUSY && bus.mem_resp) ? (N_REQ'(1) << grant_q) : '0;
  assign bus.req_rdata   = bus.mem_rdata;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q == S_BUSY);

endmodule
